// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
// rtl/ysyx_23060184_mem_arbiter_pkg.sv - shared widths, state/owner codes and request record for the memory arbiter
package ysyx_23060184_mem_arbiter_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int WMASK_LENGTH     = 4;
  localparam int ARB_STATE_LENGTH = 2;

  typedef enum logic [ARB_STATE_LENGTH-1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [WMASK_LENGTH-1:0] wmask;
  } arb_req_t;

  // Grant vector is one-hot: bit 0 = IFU, bit 1 = LSU.
  function automatic arb_owner_e grant_to_owner(input logic [1:0] gnt);
    return gnt[1] ? ARB_OWN_LSU : ARB_OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_23060184_mem_arbiter_if.sv
// rtl/ysyx_23060184_mem_arbiter_if.sv - IFU/LSU/memory bus bundle; arbiter takes slave, environment takes master
interface ysyx_23060184_mem_arbiter_if;
  import ysyx_23060184_mem_arbiter_pkg::*;

  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [DATA_WIDTH-1:0]   ifu_addr;
  logic                    ifu_resp_valid;
  logic                    ifu_resp_ready;
  logic [DATA_WIDTH-1:0]   ifu_rdata;
  logic                    ifu_resp_err;

  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic [DATA_WIDTH-1:0]   lsu_addr;
  logic                    lsu_wen;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [WMASK_LENGTH-1:0] lsu_wmask;
  logic                    lsu_resp_valid;
  logic                    lsu_resp_ready;
  logic [DATA_WIDTH-1:0]   lsu_rdata;
  logic                    lsu_resp_err;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic                    mem_wen;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [WMASK_LENGTH-1:0] mem_wmask;
  logic                    mem_resp_valid;
  logic                    mem_resp_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

endinterface

// File: rtl/ysyx_23060184_rr_pick2.sv
// rtl/ysyx_23060184_rr_pick2.sv - two-way round-robin pick; on a tie the side not granted last wins
module ysyx_23060184_rr_pick2
  import ysyx_23060184_mem_arbiter_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  arb_owner_e last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (ifu_valid_i && lsu_valid_i) begin
      grant_o = (last_grant_i == ARB_OWN_LSU) ? 2'b01 : 2'b10;
    end else if (ifu_valid_i) begin
      grant_o = 2'b01;
    end else if (lsu_valid_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_23060184_mem_arbiter.sv
// rtl/ysyx_23060184_mem_arbiter.sv - IFU/LSU to single memory port arbiter, one outstanding transaction
module ysyx_23060184_mem_arbiter
  import ysyx_23060184_mem_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          resetn,
  ysyx_23060184_mem_arbiter_if.slave    bus,
  output logic                          busy
);

  arb_state_e              state_q, state_d;
  arb_owner_e              owner_q, owner_d;
  arb_owner_e              last_grant_q, last_grant_d;
  arb_req_t                req_q, req_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [1:0]              grant;
  logic                    ifu_req_ready, lsu_req_ready;
  logic                    ifu_resp_valid, lsu_resp_valid;
  logic                    mem_req_valid, mem_resp_ready;

  ysyx_23060184_rr_pick2 u_pick (
    .ifu_valid_i  (bus.ifu_req_valid),
    .lsu_valid_i  (bus.lsu_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_OWN_IFU;
      last_grant_q <= ARB_OWN_LSU;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    req_d          = req_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        ifu_req_ready = grant[0];
        lsu_req_ready = grant[1];
        if (grant != 2'b00) begin
          owner_d      = grant_to_owner(grant);
          last_grant_d = grant_to_owner(grant);
          state_d      = ARB_REQ;
          if (grant[1]) begin
            req_d.addr  = bus.lsu_addr;
            req_d.wen   = bus.lsu_wen;
            req_d.wdata = bus.lsu_wdata;
            req_d.wmask = bus.lsu_wmask;
          end else begin
            // Fetches are reads; the write fields are forced clean.
            req_d.addr  = bus.ifu_addr;
            req_d.wen   = 1'b0;
            req_d.wdata = '0;
            req_d.wmask = '0;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        mem_resp_ready = 1'b1;
        if (bus.mem_resp_valid) begin
          rdata_d = bus.mem_rdata;
          err_d   = bus.mem_resp_err;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if (owner_q == ARB_OWN_IFU) begin
          ifu_resp_valid = 1'b1;
          if (bus.ifu_resp_ready) state_d = ARB_IDLE;
        end else begin
          lsu_resp_valid = 1'b1;
          if (bus.lsu_resp_ready) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.ifu_req_ready  = ifu_req_ready;
  assign bus.lsu_req_ready  = lsu_req_ready;
  assign bus.ifu_resp_valid = ifu_resp_valid;
  assign bus.lsu_resp_valid = lsu_resp_valid;

  // Response data is steered to the owner only so the idle side never sees stale values.
  assign bus.ifu_rdata      = (owner_q == ARB_OWN_IFU) ? rdata_q : '0;
  assign bus.ifu_resp_err   = (owner_q == ARB_OWN_IFU) ? err_q   : 1'b0;
  assign bus.lsu_rdata      = (owner_q == ARB_OWN_LSU) ? rdata_q : '0;
  assign bus.lsu_resp_err   = (owner_q == ARB_OWN_LSU) ? err_q   : 1'b0;

  assign bus.mem_req_valid  = mem_req_valid;
  assign bus.mem_resp_ready = mem_resp_ready;
  assign bus.mem_addr       = req_q.addr;
  assign bus.mem_wen        = req_q.wen;
  assign bus.mem_wdata      = req_q.wdata;
  assign bus.mem_wmask      = req_q.wmask;

  assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// tb/tb_ysyx_23060184_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_23060184_mem_arbiter;

  logic clk;
  logic resetn;
  logic busy;
  int   n_cmp;
  int   n_err;

  ysyx_23060184_mem_arbiter_if bus ();

  ysyx_23060184_mem_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.ifu_req_valid = 0; bus.ifu_addr = 0; bus.ifu_resp_ready = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0;
    bus.lsu_wdata = 0; bus.lsu_wmask = 0; bus.lsu_resp_ready = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
    step();
    step();

    // reset state
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_resp_ready", bus.mem_resp_ready, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", bus.lsu_resp_valid, 0);
    chk("rst_ifu_req_ready", bus.ifu_req_ready, 0);
    chk("rst_ifu_rdata", bus.ifu_rdata, 0);
    step();
    resetn = 1'b1;

    // IFU only fetch, minimum turnaround
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000;
    settle();
    chk("t1_ifu_req_ready", bus.ifu_req_ready, 1);
    chk("t1_lsu_req_ready", bus.lsu_req_ready, 0);
    chk("t1_busy_idle", busy, 0);
    step();
    bus.ifu_req_valid = 0; bus.ifu_addr = 0; bus.mem_req_ready = 1;
    settle();
    chk("t1_mem_req_valid", bus.mem_req_valid, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
    chk("t1_mem_wen", bus.mem_wen, 0);
    chk("t1_busy", busy, 1);
    chk("t1_mem_resp_ready_req", bus.mem_resp_ready, 0);
    step();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0413;
    settle();
    chk("t1_mem_resp_ready", bus.mem_resp_ready, 1);
    chk("t1_mem_req_valid_wait", bus.mem_req_valid, 0);
    chk("t1_ifu_resp_valid_wait", bus.ifu_resp_valid, 0);
    step();
    bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.ifu_resp_ready = 1;
    settle();
    chk("t1_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("t1_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_resp_valid", bus.lsu_resp_valid, 0);
    step();
    bus.ifu_resp_ready = 0;
    settle();
    chk("t1_busy_after", busy, 0);
    chk("t1_ifu_resp_valid_after", bus.ifu_resp_valid, 0);
    step();

    // LSU store, IFU raised mid-transaction must not be accepted
    bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'b0011;
    settle();
    chk("t2_lsu_req_ready", bus.lsu_req_ready, 1);
    chk("t2_ifu_req_ready", bus.ifu_req_ready, 0);
    step();
    bus.lsu_req_valid = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0; bus.lsu_addr = 0;
    bus.mem_req_ready = 1; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0100;
    settle();
    chk("t2_mem_addr", bus.mem_addr, 32'h8000_1000);
    chk("t2_mem_wen", bus.mem_wen, 1);
    chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wmask", bus.mem_wmask, 4'b0011);
    chk("t2_ifu_req_ready_req", bus.ifu_req_ready, 0);
    step();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 0; bus.mem_resp_err = 0;
    settle();
    chk("t2_ifu_req_ready_wait", bus.ifu_req_ready, 0);
    step();
    bus.mem_resp_valid = 0; bus.lsu_resp_ready = 1; bus.ifu_req_valid = 0; bus.ifu_addr = 0;
    settle();
    chk("t2_lsu_resp_valid", bus.lsu_resp_valid, 1);
    chk("t2_lsu_resp_err", bus.lsu_resp_err, 0);
    chk("t2_ifu_resp_valid", bus.ifu_resp_valid, 0);
    chk("t2_ifu_req_ready_done", bus.ifu_req_ready, 0);
    step();
    bus.lsu_resp_ready = 0;

    // both requesters valid from reset, three back-to-back grants IFU, LSU, IFU
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic exp_ifu;
      exp_ifu = (i != 1);
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h0000_0100;
      bus.lsu_req_valid = 1; bus.lsu_addr = 32'h0000_0200;
      settle();
      chk($sformatf("t3_%0d_ifu_req_ready", i), bus.ifu_req_ready, exp_ifu);
      chk($sformatf("t3_%0d_lsu_req_ready", i), bus.lsu_req_ready, !exp_ifu);
      step();
      if (exp_ifu) bus.ifu_req_valid = 0; else bus.lsu_req_valid = 0;
      bus.mem_req_ready = 1;
      settle();
      chk($sformatf("t3_%0d_mem_addr", i), bus.mem_addr, exp_ifu ? 32'h0000_0100 : 32'h0000_0200);
      chk($sformatf("t3_%0d_loser_ready", i), exp_ifu ? bus.lsu_req_ready : bus.ifu_req_ready, 0);
      step();
      bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_1000 + i;
      step();
      bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
      settle();
      chk($sformatf("t3_%0d_ifu_resp_valid", i), bus.ifu_resp_valid, exp_ifu);
      chk($sformatf("t3_%0d_lsu_resp_valid", i), bus.lsu_resp_valid, !exp_ifu);
      chk($sformatf("t3_%0d_rdata", i), exp_ifu ? bus.ifu_rdata : bus.lsu_rdata, 32'h0000_1000 + i);
      step();
      bus.ifu_resp_ready = 0; bus.lsu_resp_ready = 0;
    end
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.ifu_addr = 0; bus.lsu_addr = 0;
    settle();
    chk("t3_busy_end", busy, 0);
    step();

    // stalls: mem_req_ready low for 5 cycles, then lsu_resp_ready low for 3
    bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 0; bus.lsu_wmask = 4'hF;
    settle();
    chk("t4_lsu_req_ready", bus.lsu_req_ready, 1);
    step();
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wmask = 0;
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_3000;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_req_stall_%0d_valid", i), bus.mem_req_valid, 1);
      chk($sformatf("t4_req_stall_%0d_addr", i), bus.mem_addr, 32'h8000_2000);
      chk($sformatf("t4_req_stall_%0d_wmask", i), bus.mem_wmask, 4'hF);
      chk($sformatf("t4_req_stall_%0d_busy", i), busy, 1);
      chk($sformatf("t4_req_stall_%0d_ifu_ready", i), bus.ifu_req_ready, 0);
      step();
    end
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_resp_valid = 0; bus.mem_rdata = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t4_resp_stall_%0d_valid", i), bus.lsu_resp_valid, 1);
      chk($sformatf("t4_resp_stall_%0d_rdata", i), bus.lsu_rdata, 32'hCAFE_F00D);
      chk($sformatf("t4_resp_stall_%0d_busy", i), busy, 1);
      chk($sformatf("t4_resp_stall_%0d_ifu_ready", i), bus.ifu_req_ready, 0);
      step();
    end
    bus.lsu_resp_ready = 1; bus.ifu_req_valid = 0; bus.ifu_addr = 0;
    settle();
    chk("t4_lsu_resp_valid_final", bus.lsu_resp_valid, 1);
    step();
    bus.lsu_resp_ready = 0;
    settle();
    chk("t4_busy_after", busy, 0);
    step();

    // memory error on an IFU fetch
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0004;
    settle();
    chk("t5_ifu_req_ready", bus.ifu_req_ready, 1);
    step();
    bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_err = 1; bus.mem_rdata = 0;
    step();
    bus.mem_resp_valid = 0; bus.mem_resp_err = 0; bus.ifu_resp_ready = 1;
    settle();
    chk("t5_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("t5_ifu_resp_err", bus.ifu_resp_err, 1);
    chk("t5_lsu_resp_err", bus.lsu_resp_err, 0);
    chk("t5_lsu_resp_valid", bus.lsu_resp_valid, 0);
    step();
    bus.ifu_resp_ready = 0;

    // reset while waiting for the memory response
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0008;
    step();
    bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    settle();
    chk("t6_wait_resp_ready", bus.mem_resp_ready, 1);
    chk("t6_wait_busy", busy, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    settle();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("t6_rst_mem_resp_ready", bus.mem_resp_ready, 0);
    chk("t6_rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
    chk("t6_rst_lsu_resp_valid", bus.lsu_resp_valid, 0);
    chk("t6_rst_mem_addr", bus.mem_addr, 0);
    step();
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_000C;
    settle();
    chk("t6_ifu_req_ready", bus.ifu_req_ready, 1);
    step();
    bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
    settle();
    chk("t6_mem_addr", bus.mem_addr, 32'h8000_000C);
    step();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0010_0093;
    step();
    bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.ifu_resp_ready = 1;
    settle();
    chk("t6_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("t6_ifu_rdata", bus.ifu_rdata, 32'h0010_0093);
    step();
    bus.ifu_resp_ready = 0;
    settle();
    chk("t6_busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
